ib_slot_allocator: RTL and testbench

//   Upstream feeder of the IRT. Accepts decoded instructions (rd, rs1, rs2) over a

---
 rtl/ib_slot_allocator.sv | 104 ++++++++++
 tb/tb_ib_slot_allocator.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ib_slot_allocator.sv
// Instruction-buffer slot allocator. Hands the lowest free slot to each
// accepted decoded instruction and presents {slot, rd, rs1, rs2} one cycle
// later with a single-cycle strobe. Slots come back on retire and are all
// released on flush.
module ib_slot_allocator #(
    parameter int bs     = 16,
    parameter int regnum = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [$clog2(regnum)-1:0] in_rd,
    input  logic [$clog2(regnum)-1:0] in_rs1,
    input  logic [$clog2(regnum)-1:0] in_rs2,
    input  logic                      free_valid,
    input  logic [$clog2(bs)-1:0]     free_index,
    input  logic                      flush,
    output logic                      out_valid,
    output logic [$clog2(bs)-1:0]     buffer_index,
    output logic [$clog2(regnum)-1:0] rd,
    output logic [$clog2(regnum)-1:0] rs1,
    output logic [$clog2(regnum)-1:0] rs2,
    output logic [$clog2(bs):0]       count,
    output logic                      full,
    output logic                      empty,
    output logic                      err_dbl_free
);
    localparam int iw = $clog2(bs);
    localparam int cw = iw + 1;

    logic [bs-1:0] busy, busy_nxt;
    logic [cw-1:0] cnt;
    logic [iw-1:0] slot;
    logic          accept, free_hit, free_miss;

    assign count    = cnt;
    assign full     = (cnt == cw'(bs));
    assign empty    = (cnt == '0);
    assign in_ready = !full && !flush;
    assign accept   = in_valid && in_ready;

    // Flush wins over retire; a retire of a slot not marked busy is a double free.
    assign free_hit  = !flush && free_valid &&  busy[free_index];
    assign free_miss = !flush && free_valid && !busy[free_index];

    // Lowest-index free slot; scanning downward lets the lowest index win.
    // When full no accept happens, so the value is unused.
    always_comb begin
        slot = '0;
        for (int i = bs - 1; i >= 0; i--)
            if (!busy[i]) slot = iw'(i);
    end

    // Bitmap update. Allocation uses the pre-edge bitmap, so a slot retired
    // this cycle cannot be handed out until the next one. The allocated slot
    // and the freed slot never coincide (one is free, the other busy).
    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            if (free_hit) busy_nxt[free_index] = 1'b0;
            if (accept)   busy_nxt[slot]       = 1'b1;
        end
    end

    // Occupancy state, counter and sticky double-free flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy         <= '0;
            cnt          <= '0;
            err_dbl_free <= 1'b0;
        end else begin
            busy <= busy_nxt;
            if (flush)
                cnt <= '0;
            else if (accept && !free_hit)
                cnt <= cnt + 1'b1;
            else if (!accept && free_hit)
                cnt <= cnt - 1'b1;
            if (free_miss) err_dbl_free <= 1'b1;
        end
    end

    // Result strobe and payload; payload holds its value between allocations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            buffer_index <= '0;
            rd           <= '0;
            rs1          <= '0;
            rs2          <= '0;
        end else begin
            out_valid <= accept;
            if (accept) begin
                buffer_index <= slot;
                rd           <= in_rd;
                rs1          <= in_rs1;
                rs2          <= in_rs2;
            end
        end
    end
endmodule

// File: tb/tb_ib_slot_allocator.sv
// Directed bench for ib_slot_allocator: allocation order, latency, full/free
// interplay, same-cycle alloc+free, double free, flush and async reset.
module tb_ib_slot_allocator;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready;
    logic [3:0] in_rd, in_rs1, in_rs2;
    logic       free_valid;
    logic [3:0] free_index;
    logic       flush;
    logic       out_valid;
    logic [3:0] buffer_index, rd, rs1, rs2;
    logic [4:0] count;
    logic       full, empty, err_dbl_free;

    int n_chk  = 0;
    int n_fail = 0;

    ib_slot_allocator #(.bs(16), .regnum(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .free_valid(free_valid), .free_index(free_index), .flush(flush),
        .out_valid(out_valid), .buffer_index(buffer_index),
        .rd(rd), .rs1(rs1), .rs2(rs2),
        .count(count), .full(full), .empty(empty), .err_dbl_free(err_dbl_free)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        in_valid = 1'b1; in_rd = a; in_rs1 = b; in_rs2 = c;
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0;
        free_valid = 0; free_index = 0; flush = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        // Reset state
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_oval", out_valid, 0);
        chk("rst_err", err_dbl_free, 0);

        // Back-to-back accepts
        drive(3, 5, 7); tick();
        chk("b2b0_oval", out_valid, 1);
        chk("b2b0_idx", buffer_index, 0);
        chk("b2b0_regs", {rd, rs1, rs2}, 12'h357);
        drive(2, 6, 9); tick();
        chk("b2b1_idx", buffer_index, 1);
        chk("b2b1_regs", {rd, rs1, rs2}, 12'h269);
        drive(1, 4, 8); tick();
        chk("b2b2_idx", buffer_index, 2);
        chk("b2b2_regs", {rd, rs1, rs2}, 12'h148);
        in_valid = 0; tick();
        chk("b2b_oval_drop", out_valid, 0);
        chk("b2b_hold_rd", rd, 1);
        chk("b2b_count", count, 3);

        // Fill slots 3..15
        drive(0, 0, 0);
        repeat (13) tick();
        chk("fill_last_idx", buffer_index, 15);
        chk("fill_full", full, 1);
        chk("fill_count", count, 16);
        chk("fill_ready", in_ready, 0);
        drive(9, 9, 9); tick();
        chk("full_held", out_valid, 0);
        chk("full_hold_rd", rd, 0);
        free_valid = 1; free_index = 8; #1;
        chk("free_full_ready", in_ready, 0);
        tick();
        free_valid = 0;
        chk("free_oval", out_valid, 0);
        chk("free_count", count, 15);
        chk("free_ready_next", in_ready, 1);
        tick();
        chk("realloc_oval", out_valid, 1);
        chk("realloc_idx", buffer_index, 8);
        chk("realloc_full", full, 1);
        in_valid = 0;

        // Flush, then occupy slots 0..4
        flush = 1; tick(); flush = 0;
        chk("flush_count", count, 0);
        drive(0, 0, 0);
        repeat (5) tick();
        chk("five_count", count, 5);
        // Same-cycle alloc + free of slot 0
        free_valid = 1; free_index = 0; tick(); free_valid = 0;
        chk("af_idx", buffer_index, 5);
        chk("af_count", count, 5);
        tick(); in_valid = 0;
        chk("af_reuse_idx", buffer_index, 0);
        chk("af_count2", count, 6);

        // Double free of free slot 10
        free_valid = 1; free_index = 10; tick(); free_valid = 0;
        chk("dbl_err", err_dbl_free, 1);
        chk("dbl_count", count, 6);
        tick();
        chk("dbl_err_sticky", err_dbl_free, 1);

        // Flush with in_valid
        flush = 1; drive(4, 4, 4); #1;
        chk("flush_ready", in_ready, 0);
        tick(); flush = 0; in_valid = 0;
        tick();
        chk("flush_oval", out_valid, 0);
        chk("flush_count2", count, 0);
        chk("flush_empty", empty, 1);
        chk("flush_err_kept", err_dbl_free, 1);
        drive(4, 5, 6); tick();
        chk("post_flush_idx", buffer_index, 0);
        chk("post_flush_oval", out_valid, 1);
        drive(7, 7, 7); tick();
        chk("post_flush_idx1", buffer_index, 1);

        // Async reset between edges
        #2 rst = 1'b1; in_valid = 0;
        #1;
        chk("arst_oval", out_valid, 0);
        chk("arst_count", count, 0);
        chk("arst_idx", buffer_index, 0);
        chk("arst_regs", {rd, rs1, rs2}, 0);
        chk("arst_err", err_dbl_free, 0);
        chk("arst_empty", empty, 1);
        @(negedge clk) rst = 1'b0;

        // Free of the slot being allocated this cycle
        drive(2, 3, 4); free_valid = 1; free_index = 0; tick();
        free_valid = 0; in_valid = 0;
        chk("selffree_idx", buffer_index, 0);
        chk("selffree_oval", out_valid, 1);
        chk("selffree_err", err_dbl_free, 1);
        chk("selffree_count", count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
